// File: rtl/fb_draw_engine_if.sv
// rtl/fb_draw_engine_if.sv - command and back-buffer write bundle for the draw engine
// master = command source / framebuffer side, slave = draw engine.
interface fb_draw_engine_if #(
  parameter int RES_X      = 320,
  parameter int RES_Y      = 240,
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(RES_X*RES_Y),
  parameter int X_BITS     = $clog2(RES_X),
  parameter int Y_BITS     = $clog2(RES_Y)
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [X_BITS-1:0]     cmd_x0;
  logic [Y_BITS-1:0]     cmd_y0;
  logic [X_BITS-1:0]     cmd_x1;
  logic [Y_BITS-1:0]     cmd_y1;
  logic [MEM_WIDTH-1:0]  cmd_color;
  logic                  frame_start;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  din;
  logic                  wen;
  logic                  swap_buf;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, frame_start,
    input  cmd_ready, mem_addr, din, wen, swap_buf, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, frame_start,
    output cmd_ready, mem_addr, din, wen, swap_buf, busy
  );
endinterface

// File: rtl/fb_draw_engine.sv
// rtl/fb_draw_engine.sv - command-driven rectangle/clear/swap writer for a double-buffered framebuffer
// One pixel per clock in raster order; swaps block until the display reports a new frame.
module fb_draw_engine #(
  parameter int RES_X      = 320,
  parameter int RES_Y      = 240,
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(RES_X*RES_Y),
  parameter int X_BITS     = $clog2(RES_X),
  parameter int Y_BITS     = $clog2(RES_Y)
) (
  input  logic           clk,
  input  logic           rst,
  fb_draw_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, SWAP_PULSE, WAIT_FRAME} state_t;

  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_SWAP  = 2'd2;

  localparam logic [X_BITS-1:0]     X_MAX    = X_BITS'(RES_X - 1);
  localparam logic [Y_BITS-1:0]     Y_MAX    = Y_BITS'(RES_Y - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(RES_X);

  state_t                state_q, state_d;
  logic [X_BITS-1:0]     x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [Y_BITS-1:0]     y_q, y_d, y1_q, y1_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  din_q, din_d;
  logic                  wen_q, wen_d;
  logic                  swap_q, swap_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  is_clear;
  logic [X_BITS-1:0]     sx0, sx1;
  logic [Y_BITS-1:0]     sy0, sy1;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] start_addr;

  assign accept   = bus.cmd_valid && ready_q;
  assign is_clear = (bus.cmd_op == OP_CLEAR);

  // Clamp to the visible area; CLEAR is just a full-screen fill.
  assign sx0 = is_clear ? '0    : ((bus.cmd_x0 > X_MAX) ? X_MAX : bus.cmd_x0);
  assign sx1 = is_clear ? X_MAX : ((bus.cmd_x1 > X_MAX) ? X_MAX : bus.cmd_x1);
  assign sy0 = is_clear ? '0    : ((bus.cmd_y0 > Y_MAX) ? Y_MAX : bus.cmd_y0);
  assign sy1 = is_clear ? Y_MAX : ((bus.cmd_y1 > Y_MAX) ? Y_MAX : bus.cmd_y1);
  assign empty = (sx0 > sx1) || (sy0 > sy1);

  // Constant multiply only at accept; the per-pixel path just adds.
  assign start_addr = ADDR_WIDTH'(sy0) * ROW_STEP + ADDR_WIDTH'(sx0);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    din_d      = din_q;
    wen_d      = 1'b0;
    swap_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((bus.cmd_op == OP_FILL || is_clear) && !empty) begin
            state_d    = FILL;
            wen_d      = 1'b1;
            addr_d     = start_addr;
            row_base_d = start_addr;
            din_d      = bus.cmd_color;
            x_d        = sx0;
            y_d        = sy0;
            x0_d       = sx0;
            x1_d       = sx1;
            y1_d       = sy1;
          end else if (bus.cmd_op == OP_SWAP) begin
            state_d = SWAP_PULSE;
            swap_d  = 1'b1;
          end
        end
      end
      FILL: begin
        if (x_q == x1_q && y_q == y1_q) begin
          state_d = IDLE;
        end else if (x_q == x1_q) begin
          wen_d      = 1'b1;
          x_d        = x0_q;
          y_d        = y_q + 1'b1;
          row_base_d = row_base_q + ROW_STEP;
          addr_d     = row_base_q + ROW_STEP;
        end else begin
          wen_d  = 1'b1;
          x_d    = x_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      SWAP_PULSE: state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        // A strobe during the pulse cycle is never seen here, so it is ignored.
        if (bus.frame_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) && !accept;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      wen_q      <= 1'b0;
      swap_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      wen_q      <= wen_d;
      swap_q     <= swap_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.mem_addr  = addr_q;
  assign bus.din       = din_q;
  assign bus.wen       = wen_q;
  assign bus.swap_buf  = swap_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fb_draw_engine.sv
// tb/tb_fb_draw_engine.sv - self-checking bench for fb_draw_engine
// Vector table, randomized fills against a raster-list model, and hand sequences for swap and reset.
module tb_fb_draw_engine;
  localparam int RES_X      = 320;
  localparam int RES_Y      = 240;
  localparam int MEM_WIDTH  = 8;
  localparam int ADDR_WIDTH = $clog2(RES_X*RES_Y);
  localparam int X_BITS     = $clog2(RES_X);
  localparam int Y_BITS     = $clog2(RES_Y);
  localparam int BOUND      = 80000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   swap_cnt = 0;

  fb_draw_engine_if #(
    .RES_X(RES_X), .RES_Y(RES_Y), .MEM_WIDTH(MEM_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .X_BITS(X_BITS), .Y_BITS(Y_BITS)
  ) bus_if ();

  fb_draw_engine #(
    .RES_X(RES_X), .RES_Y(RES_Y), .MEM_WIDTH(MEM_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .X_BITS(X_BITS), .Y_BITS(Y_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_if.swap_buf === 1'b1) swap_cnt++;

  typedef struct {
    string name;
    int op, x0, y0, x1, y1, color;
    int exp_n, exp_first, exp_last, exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one command and observes writes until the engine is ready again.
  task automatic do_cmd(input int op, input int x0, input int y0, input int x1, input int y1,
                        input int color, output int en, output int n, output int first,
                        output int last, output int lat, output int bad);
    int exp_addr[$];
    int cx0, cy0, cx1, cy1, t, k;
    int mx0, my0, mx1, my1;
    mx0 = x0 % (1 << X_BITS); mx1 = x1 % (1 << X_BITS);
    my0 = y0 % (1 << Y_BITS); my1 = y1 % (1 << Y_BITS);
    if (op == 1) begin
      cx0 = 0; cy0 = 0; cx1 = RES_X - 1; cy1 = RES_Y - 1;
    end else begin
      cx0 = (mx0 > RES_X - 1) ? RES_X - 1 : mx0;
      cx1 = (mx1 > RES_X - 1) ? RES_X - 1 : mx1;
      cy0 = (my0 > RES_Y - 1) ? RES_Y - 1 : my0;
      cy1 = (my1 > RES_Y - 1) ? RES_Y - 1 : my1;
    end
    if (op <= 1)
      for (int y = cy0; y <= cy1; y++)
        for (int x = cx0; x <= cx1; x++)
          exp_addr.push_back(y * RES_X + x);
    en = exp_addr.size();

    t = 0;
    while (bus_if.cmd_ready !== 1'b1 && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) check("ready_wait", 0, 1);

    bus_if.cmd_op    = op[1:0];
    bus_if.cmd_x0    = X_BITS'(mx0);
    bus_if.cmd_y0    = Y_BITS'(my0);
    bus_if.cmd_x1    = X_BITS'(mx1);
    bus_if.cmd_y1    = Y_BITS'(my1);
    bus_if.cmd_color = MEM_WIDTH'(color);
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;

    n = 0; bad = 0; first = -1; last = -1; lat = -1;
    for (k = 1; k <= BOUND; k++) begin
      if (bus_if.wen === 1'b1) begin
        if (n >= exp_addr.size()) bad++;
        else if (int'(bus_if.mem_addr) != exp_addr[n]) bad++;
        if (int'(bus_if.din) != (color % 256) || k != n + 1 || bus_if.busy !== 1'b1) bad++;
        if (n == 0) first = int'(bus_if.mem_addr);
        last = int'(bus_if.mem_addr);
        n++;
      end
      if (bus_if.cmd_ready === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int en, n, first, last, lat, bad, base, wr;

    vecs.push_back('{"single",  0,   5,   3,  5,   3, 8'h2A,     1,     965,   965,     2});
    vecs.push_back('{"rect",    0,  10,   1, 12,   2, 8'h15,     6,     330,   652,     7});
    vecs.push_back('{"clamp",   0, 318, 238, 400, 255, 8'h3F,    4,   76478, 76799,     5});
    vecs.push_back('{"empty",   0,  20,   0, 10,   5, 8'h01,     0,      -1,    -1,     2});
    vecs.push_back('{"nop",     3,   1,   1,  2,   2, 8'h01,     0,      -1,    -1,     2});
    vecs.push_back('{"row0",    0,   0,   0, 319,  0, 8'h01,   320,       0,   319,   321});
    vecs.push_back('{"column",  0,   7,   9,  7,  11, 8'h30,     3,    2887,  3527,     4});
    vecs.push_back('{"clear",   1,   0,   0,  0,   0, 8'h00, 76800,       0, 76799, 76801});

    bus_if.cmd_valid = 1'b0; bus_if.cmd_op = 2'd3;
    bus_if.cmd_x0 = '0; bus_if.cmd_y0 = '0; bus_if.cmd_x1 = '0; bus_if.cmd_y1 = '0;
    bus_if.cmd_color = '0; bus_if.frame_start = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus_if.cmd_ready), 0);
    check("rst_wen",   int'(bus_if.wen), 0);
    check("rst_busy",  int'(bus_if.busy), 0);
    check("rst_swap",  int'(bus_if.swap_buf), 0);
    check("rst_addr",  int'(bus_if.mem_addr), 0);
    check("rst_din",   int'(bus_if.din), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", int'(bus_if.cmd_ready), 1);

    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color,
             en, n, first, last, lat, bad);
      check({vecs[i].name, "_n"},     n,     vecs[i].exp_n);
      check({vecs[i].name, "_model"}, en,    vecs[i].exp_n);
      check({vecs[i].name, "_first"}, first, vecs[i].exp_first);
      check({vecs[i].name, "_last"},  last,  vecs[i].exp_last);
      check({vecs[i].name, "_lat"},   lat,   vecs[i].exp_lat);
      check({vecs[i].name, "_seq"},   bad,   0);
    end

    for (int r = 0; r < 20; r++) begin
      int rx0, ry0, rx1, ry1, op;
      op  = ($urandom_range(0, 7) == 0) ? 3 : 0;
      rx0 = int'($urandom_range(0, 330));
      ry0 = int'($urandom_range(0, 250));
      rx1 = rx0 + int'($urandom_range(0, 14)) - 2;
      ry1 = ry0 + int'($urandom_range(0, 4)) - 1;
      if (rx1 < 0) rx1 = 0;
      if (rx1 > 511) rx1 = 511;
      if (ry1 < 0) ry1 = 0;
      if (ry1 > 255) ry1 = 255;
      do_cmd(op, rx0, ry0, rx1, ry1, int'($urandom_range(0, 63)), en, n, first, last, lat, bad);
      check("rand_n",   n,   en);
      check("rand_lat", lat, (en == 0) ? 2 : en + 1);
      check("rand_seq", bad, 0);
    end

    // Swap with a coincident frame_start, a long wait, and a FILL queued behind it.
    base = swap_cnt;
    bus_if.cmd_op = 2'd2; bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    check("swap_pulse", int'(bus_if.swap_buf), 1);
    check("swap_rdy_lo", int'(bus_if.cmd_ready), 0);
    bus_if.frame_start = 1'b1;
    bus_if.cmd_op = 2'd0; bus_if.cmd_x0 = 9'd5; bus_if.cmd_y0 = 8'd3;
    bus_if.cmd_x1 = 9'd5; bus_if.cmd_y1 = 8'd3; bus_if.cmd_color = 8'h2A;
    @(negedge clk);
    check("swap_pulse_end", int'(bus_if.swap_buf), 0);
    check("swap_coinc_ign", int'(bus_if.cmd_ready), 0);
    bus_if.frame_start = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_if.cmd_ready !== 1'b0 || bus_if.swap_buf !== 1'b0 || bus_if.wen !== 1'b0) bad++;
    end
    check("swap_hold", bad, 0);
    bus_if.frame_start = 1'b1;
    @(negedge clk);
    check("swap_release", int'(bus_if.cmd_ready), 1);
    check("swap_no_early_wr", int'(bus_if.wen), 0);
    @(negedge clk);
    bus_if.frame_start = 1'b0;
    bus_if.cmd_valid = 1'b0;
    check("queued_wen",  int'(bus_if.wen), 1);
    check("queued_addr", int'(bus_if.mem_addr), 965);
    check("queued_din",  int'(bus_if.din), 8'h2A);
    check("queued_rdy",  int'(bus_if.cmd_ready), 0);
    @(negedge clk);
    check("queued_done", int'(bus_if.cmd_ready), 1);
    check("swap_count", swap_cnt - base, 1);

    // Reset during the 50th CLEAR write.
    bus_if.cmd_op = 2'd1; bus_if.cmd_color = 8'h11; bus_if.cmd_valid = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    wr = 0;
    for (int c = 0; c < 200 && wr < 50; c++) begin
      if (bus_if.wen === 1'b1) wr++;
      if (wr < 50) @(negedge clk);
    end
    check("mid_wen",  int'(bus_if.wen), 1);
    check("mid_addr", int'(bus_if.mem_addr), 49);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wen",  int'(bus_if.wen), 0);
    check("mid_rst_busy", int'(bus_if.busy), 0);
    check("mid_rst_rdy",  int'(bus_if.cmd_ready), 0);
    check("mid_rst_addr", int'(bus_if.mem_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", int'(bus_if.cmd_ready), 1);
    check("post_rst_wen", int'(bus_if.wen), 0);
    do_cmd(0, 10, 1, 12, 2, 8'h15, en, n, first, last, lat, bad);
    check("post_rst_n",     n, 6);
    check("post_rst_first", first, 330);
    check("post_rst_lat",   lat, 7);
    check("post_rst_seq",   bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
